// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update path: counter encodings,
// controller state, queue entry layout and saturating counter helpers.
package bp_pkg;

  localparam logic [1:0] UU = 2'b00;
  localparam logic [1:0] UT = 2'b01;
  localparam logic [1:0] TU = 2'b10;
  localparam logic [1:0] TT = 2'b11;

  // Index width carried by the queue entry; must match the controller's INDEX_WIDTH.
  localparam int BP_INDEX_W = 6;

  typedef enum logic [1:0] {INIT, IDLE, WRITE} bp_state_t;

  typedef struct packed {
    logic [1:0]            bank;
    logic [BP_INDEX_W-1:0] index;
    logic                  taken;
  } bp_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    case (c)
      UU:      return UT;
      UT:      return TU;
      default: return TT;
    endcase
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    case (c)
      TT:      return TU;
      TU:      return UT;
      default: return UU;
    endcase
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Counter-table access bundle: one read port (data one cycle after strobe)
// and one write port. master = update controller, slave = table.
interface bp_update_ctrl_if #(
  parameter int AW = 8
);
  logic          tbl_rd_en;
  logic [AW-1:0] tbl_rd_addr;
  logic [1:0]    tbl_rd_data;
  logic          tbl_wr_en;
  logic [AW-1:0] tbl_wr_addr;
  logic [1:0]    tbl_wr_data;

  modport master (
    output tbl_rd_en, tbl_rd_addr, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  tbl_rd_data
  );

  modport slave (
    input  tbl_rd_en, tbl_rd_addr, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output tbl_rd_data
  );
endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// Generic synchronous FIFO with clear; head visible on dout (fall-through).
// Latency: pushed word visible at dout the cycle after push into an empty queue.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module bp_update_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor table writer: init sweep, then queued read-modify-write counter updates.
// Latency: queued update reads next idle cycle, writes the cycle after (one update / 2 cycles).
// Backpressure: none upstream; an update arriving to a full queue is lost with a drop pulse.
// Optional BP_UPDATE_STATS_EN adds saturating upd_count/drop_count outputs.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int         INDEX_WIDTH = BP_INDEX_W,
  parameter int         DEPTH       = 4,
  parameter logic [1:0] INIT_STATE  = UT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stallE,
  input  logic                   BranchOpEb0,
  input  logic                   PCSrcResE,
  input  logic [1:0]             LocalSrcE,
  input  logic [INDEX_WIDTH-1:0] PCIndexE,
  input  logic                   flush_req,
  bp_update_ctrl_if.master       tbl,
  output logic                   init_done,
  output logic                   drop
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [15:0]            upd_count,
  output logic [15:0]            drop_count
`endif
);
  localparam int AW = INDEX_WIDTH + 2;

  bp_state_t             state;
  logic [AW-1:0]         ptr;
  logic                  kill;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  bp_entry_t             enq_entry;
  bp_entry_t             head;
  logic [AW-1:0]         head_addr;

  // Reset and flush both abandon the queue and restart the sweep.
  assign kill      = reset || flush_req;
  assign push      = BranchOpEb0 && !stallE && !kill;
  assign pop       = (state == WRITE) && !kill;
  assign drop      = push && fifo_full && !pop;
  assign enq_entry = '{bank: LocalSrcE, index: PCIndexE, taken: PCSrcResE};
  assign head_addr = {head.bank, head.index};

  bp_update_fifo #(
    .WIDTH ($bits(bp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_req),
    .push  (push),
    .pop   (pop),
    .din   (enq_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tbl.tbl_rd_en   = (state == IDLE) && !fifo_empty && !kill;
  assign tbl.tbl_rd_addr = head_addr;
  assign tbl.tbl_wr_en   = ((state == INIT) || (state == WRITE)) && !kill;
  assign tbl.tbl_wr_addr = (state == INIT) ? ptr : head_addr;
  // Read data arrives in WRITE, so the new counter is formed combinationally from it.
  assign tbl.tbl_wr_data = (state == INIT) ? INIT_STATE :
                           head.taken ? sat_inc(tbl.tbl_rd_data) : sat_dec(tbl.tbl_rd_data);

  always_ff @(posedge clk) begin
    if (kill) begin
      state     <= INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + AW'(1);
          if (ptr == '1) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (!fifo_empty) state <= WRITE;
        end
        WRITE:   state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

`ifdef BP_UPDATE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pop && (upd_count != 16'hFFFF)) upd_count <= upd_count + 16'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= ($clog2(DEPTH) + 1)'(DEPTH));
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a 256-entry table model behind the interface.
module tb_bp_update_ctrl;
  logic       clk = 1'b0;
  logic       reset, stallE, BranchOpEb0, PCSrcResE, flush_req;
  logic [1:0] LocalSrcE;
  logic [5:0] PCIndexE;
  logic       init_done, drop;
  int         total = 0;
  int         bad   = 0;
  logic [1:0] tmem [256];
`ifdef BP_UPDATE_STATS_EN
  logic [15:0] upd_count, drop_count;
`endif

  always #5 clk = ~clk;

  bp_update_ctrl_if #(.AW(8)) tbl ();

  bp_update_ctrl #(.INDEX_WIDTH(6), .DEPTH(4), .INIT_STATE(2'b01)) dut (
    .clk         (clk),
    .reset       (reset),
    .stallE      (stallE),
    .BranchOpEb0 (BranchOpEb0),
    .PCSrcResE   (PCSrcResE),
    .LocalSrcE   (LocalSrcE),
    .PCIndexE    (PCIndexE),
    .flush_req   (flush_req),
    .tbl         (tbl),
    .init_done   (init_done),
    .drop        (drop)
`ifdef BP_UPDATE_STATS_EN
    ,
    .upd_count   (upd_count),
    .drop_count  (drop_count)
`endif
  );

  always @(posedge clk) begin
    if (tbl.tbl_wr_en) tmem[tbl.tbl_wr_addr] <= tbl.tbl_wr_data;
    if (tbl.tbl_rd_en) tbl.tbl_rd_data <= tmem[tbl.tbl_rd_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    #1;
    total++;
    if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop, init_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: rd,wr,drop,done=%b want 0000",
               {tbl.tbl_rd_en, tbl.tbl_wr_en, drop, init_done});
    end
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #1;
      total++;
      if ({tbl.tbl_wr_en, tbl.tbl_rd_en, init_done} !== 3'b100 ||
          tbl.tbl_wr_addr !== 8'(i) || tbl.tbl_wr_data !== 2'b01) begin
        bad++;
        $display("FAIL init_sweep[%0d]: wr,rd,done=%b addr=%h data=%b want 100 addr=%h data=01",
                 i, {tbl.tbl_wr_en, tbl.tbl_rd_en, init_done}, tbl.tbl_wr_addr, tbl.tbl_wr_data, 8'(i));
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({init_done, tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== 4'b1000) begin
        bad++;
        $display("FAIL post_init_idle[%0d]: done,rd,wr,drop=%b want 1000",
                 i, {init_done, tbl.tbl_rd_en, tbl.tbl_wr_en, drop});
      end
      cyc();
    end
  endtask

  task automatic test_single();
    BranchOpEb0 = 1'b1; LocalSrcE = 2'd2; PCIndexE = 6'd5; PCSrcResE = 1'b1;
    #1;
    total++;
    if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== 3'b000) begin
      bad++;
      $display("FAIL single_enq: rd,wr,drop=%b want 000", {tbl.tbl_rd_en, tbl.tbl_wr_en, drop});
    end
    cyc();
    BranchOpEb0 = 1'b0;
    #1;
    total++;
    if ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b10 || tbl.tbl_rd_addr !== 8'h85) begin
      bad++;
      $display("FAIL single_read: rd,wr=%b addr=%h want 10 addr=85",
               {tbl.tbl_rd_en, tbl.tbl_wr_en}, tbl.tbl_rd_addr);
    end
    cyc();
    #1;
    total++;
    if ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b01 || tbl.tbl_wr_addr !== 8'h85 ||
        tbl.tbl_wr_data !== 2'b10) begin
      bad++;
      $display("FAIL single_write: rd,wr=%b addr=%h data=%b want 01 addr=85 data=10",
               {tbl.tbl_rd_en, tbl.tbl_wr_en}, tbl.tbl_wr_addr, tbl.tbl_wr_data);
    end
    cyc();
    #1;
    total++;
    if ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b00) begin
      bad++;
      $display("FAIL single_after: rd,wr=%b want 00", {tbl.tbl_rd_en, tbl.tbl_wr_en});
    end
    cyc();
  endtask

  typedef struct packed {
    logic [1:0] b;
    logic [5:0] i;
    logic       t;
    logic [1:0] rd;
    logic [1:0] wr;
  } sat_vec_t;

  task automatic test_saturate();
    sat_vec_t v [4];
    logic [7:0] a;
    v[0] = '{b: 2'd2, i: 6'd5, t: 1'b1, rd: 2'b10, wr: 2'b11};
    v[1] = '{b: 2'd2, i: 6'd5, t: 1'b1, rd: 2'b11, wr: 2'b11};
    v[2] = '{b: 2'd1, i: 6'd3, t: 1'b0, rd: 2'b01, wr: 2'b00};
    v[3] = '{b: 2'd1, i: 6'd3, t: 1'b0, rd: 2'b00, wr: 2'b00};
    for (int n = 0; n < 4; n++) begin
      a = {v[n].b, v[n].i};
      BranchOpEb0 = 1'b1; LocalSrcE = v[n].b; PCIndexE = v[n].i; PCSrcResE = v[n].t;
      cyc();
      BranchOpEb0 = 1'b0;
      #1;
      total++;
      if (tbl.tbl_rd_en !== 1'b1 || tbl.tbl_rd_addr !== a) begin
        bad++;
        $display("FAIL sat_read[%0d]: rd=%b addr=%h want 1 addr=%h", n, tbl.tbl_rd_en, tbl.tbl_rd_addr, a);
      end
      cyc();
      #1;
      total++;
      if (tbl.tbl_wr_en !== 1'b1 || tbl.tbl_wr_addr !== a || tbl.tbl_rd_data !== v[n].rd ||
          tbl.tbl_wr_data !== v[n].wr) begin
        bad++;
        $display("FAIL sat_write[%0d]: wr=%b addr=%h rd_data=%b wr_data=%b want 1 %h %b %b",
                 n, tbl.tbl_wr_en, tbl.tbl_wr_addr, tbl.tbl_rd_data, tbl.tbl_wr_data, a, v[n].rd, v[n].wr);
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    stallE = 1'b1; BranchOpEb0 = 1'b1; LocalSrcE = 2'd0; PCIndexE = 6'd7; PCSrcResE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        stallE = 1'b0; BranchOpEb0 = 1'b0;
      end
      #1;
      total++;
      if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== 3'b000) begin
        bad++;
        $display("FAIL stall[%0d]: rd,wr,drop=%b want 000", i, {tbl.tbl_rd_en, tbl.tbl_wr_en, drop});
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [7:0] ea;
    logic exp_rd, exp_wr, exp_drop;
    for (int k = 0; k < 17; k++) begin
      if (k < 8) begin
        BranchOpEb0 = 1'b1; LocalSrcE = 2'(k); PCIndexE = 6'(20 + k); PCSrcResE = ~1'(k);
      end else begin
        BranchOpEb0 = 1'b0;
      end
      #1;
      exp_drop = (k == 7);
      exp_rd   = (k % 2 == 1) && (k <= 13);
      exp_wr   = (k % 2 == 0) && (k >= 2) && (k <= 14);
      total++;
      if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== {exp_rd, exp_wr, exp_drop}) begin
        bad++;
        $display("FAIL b2b_strobes[%0d]: rd,wr,drop=%b want %b", k,
                 {tbl.tbl_rd_en, tbl.tbl_wr_en, drop}, {exp_rd, exp_wr, exp_drop});
      end
      if (exp_rd) begin
        e  = (k - 1) / 2;
        ea = {2'(e), 6'(20 + e)};
        total++;
        if (tbl.tbl_rd_addr !== ea) begin
          bad++;
          $display("FAIL b2b_rd_addr[%0d]: addr=%h want %h", k, tbl.tbl_rd_addr, ea);
        end
      end
      if (exp_wr) begin
        e  = (k - 2) / 2;
        ea = {2'(e), 6'(20 + e)};
        total++;
        if (tbl.tbl_wr_addr !== ea || tbl.tbl_wr_data !== ((e % 2 == 0) ? 2'b10 : 2'b00)) begin
          bad++;
          $display("FAIL b2b_write[%0d]: addr=%h data=%b want %h %b", k, tbl.tbl_wr_addr,
                   tbl.tbl_wr_data, ea, (e % 2 == 0) ? 2'b10 : 2'b00);
        end
      end
      cyc();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      BranchOpEb0 = 1'b1; LocalSrcE = 2'd3; PCIndexE = 6'(40 + k); PCSrcResE = 1'b1;
      flush_req = (k == 4);
      #1;
      if (k == 4) begin
        total++;
        if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== 3'b000) begin
          bad++;
          $display("FAIL flush_abort: rd,wr,drop=%b want 000", {tbl.tbl_rd_en, tbl.tbl_wr_en, drop});
        end
      end
      cyc();
    end
    flush_req = 1'b0; BranchOpEb0 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < ((r == 0) ? 50 : 256); i++) begin
        #1;
        total++;
        if ({tbl.tbl_wr_en, tbl.tbl_rd_en, init_done} !== 3'b100 || tbl.tbl_wr_addr !== 8'(i)) begin
          bad++;
          $display("FAIL flush_sweep%0d[%0d]: wr,rd,done=%b addr=%h want 100 addr=%h",
                   r, i, {tbl.tbl_wr_en, tbl.tbl_rd_en, init_done}, tbl.tbl_wr_addr, 8'(i));
        end
        cyc();
      end
      if (r == 0) begin
        flush_req = 1'b1;
        #1;
        total++;
        if (tbl.tbl_wr_en !== 1'b0) begin
          bad++;
          $display("FAIL flush_in_init: wr=%b want 0", tbl.tbl_wr_en);
        end
        cyc();
        flush_req = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({init_done, tbl.tbl_rd_en, tbl.tbl_wr_en} !== 3'b100) begin
        bad++;
        $display("FAIL flush_queue_empty[%0d]: done,rd,wr=%b want 100", i,
                 {init_done, tbl.tbl_rd_en, tbl.tbl_wr_en});
      end
      cyc();
    end
  endtask

  task automatic test_init_overflow();
    logic got;
    logic [7:0] ea;
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      BranchOpEb0 = 1'b1; LocalSrcE = 2'd0; PCIndexE = 6'(50 + k); PCSrcResE = (k % 2 == 0);
      #1;
      total++;
      if ({tbl.tbl_rd_en, tbl.tbl_wr_en, drop} !== {2'b01, (k >= 4)} || tbl.tbl_wr_addr !== 8'(k)) begin
        bad++;
        $display("FAIL ovf_enq[%0d]: rd,wr,drop=%b addr=%h want %b addr=%h", k,
                 {tbl.tbl_rd_en, tbl.tbl_wr_en, drop}, tbl.tbl_wr_addr, {2'b01, (k >= 4)}, 8'(k));
      end
      cyc();
    end
    BranchOpEb0 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (init_done === 1'b1) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ovf_init_timeout: init_done=%b want 1", init_done);
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (j > 0) begin
          cyc();
          #1;
        end
        ea = {2'd0, 6'(50 + j / 2)};
        total++;
        if ((j % 2 == 0) ? ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b10 || tbl.tbl_rd_addr !== ea)
                         : ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b01 || tbl.tbl_wr_addr !== ea ||
                            tbl.tbl_wr_data !== (((j / 2) % 2 == 0) ? 2'b10 : 2'b00))) begin
          bad++;
          $display("FAIL ovf_drain[%0d]: rd,wr=%b rd_addr=%h wr_addr=%h data=%b want addr=%h",
                   j, {tbl.tbl_rd_en, tbl.tbl_wr_en}, tbl.tbl_rd_addr, tbl.tbl_wr_addr,
                   tbl.tbl_wr_data, ea);
        end
      end
      cyc();
      #1;
      total++;
      if ({tbl.tbl_rd_en, tbl.tbl_wr_en} !== 2'b00) begin
        bad++;
        $display("FAIL ovf_done: rd,wr=%b want 00", {tbl.tbl_rd_en, tbl.tbl_wr_en});
      end
      cyc();
    end
  endtask

`ifdef BP_UPDATE_STATS_EN
  task automatic test_stats();
    #1;
    total++;
    if (upd_count !== 16'd17 || drop_count !== 16'd3) begin
      bad++;
      $display("FAIL stats: upd=%0d drop=%0d want 17 3", upd_count, drop_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; stallE = 1'b0; BranchOpEb0 = 1'b0; PCSrcResE = 1'b0;
    flush_req = 1'b0; LocalSrcE = 2'd0; PCIndexE = 6'd0;
    test_reset();
    test_single();
    test_saturate();
    test_stall();
    test_back_to_back();
    test_flush();
    test_init_overflow();
`ifdef BP_UPDATE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
